apb_master_interface: RTL
=========================

APB_MASTER_INTERFACE -- requirements
Module: apb_master_interface

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 4, APB address width.
- DATA_W, 8, APB data width.
- FIFO_DEPTH, 4, command buffer entries (power of two).
- TIMEOUT, 16, maximum ACCESS cycles with Pready low before abort.

REQ-002 The block SHALL have these ports:
- PCLK  input  1  clock, rising-edge.
- Preset  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command buffer not full.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DATA_W  read data, 0 for writes.
- rsp_err  output  1  Pslverr or timeout on the completed transfer.
- rsp_timeout  output  1  transfer aborted by timeout.
- busy  output  1  FSM not IDLE or buffer non-empty.
- Psel, Penable, Pwrite  output  1 each  APB control.
- Paddr  output  ADDR_W  APB address.
- Pwdata  output  DATA_W  APB write data.
- Prdata  input  DATA_W  APB read data.
- Pready, Pslverr  input  1 each  APB completion and error.

Function
REQ-003 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1, and pushed into the FIFO.
REQ-004 cmd_ready SHALL be 0 only when the FIFO holds FIFO_DEPTH entries; there is no bypass path, and a pop on the same edge does not raise cmd_ready early.
REQ-005 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-006 In IDLE with the FIFO non-empty, the block SHALL pop one entry on the next edge and enter SETUP.
REQ-007 In SETUP, the block SHALL drive Psel=1, Penable=0, and Paddr, Pwrite and Pwdata from the popped entry; Pwdata SHALL be 0 for reads.
REQ-008 SETUP SHALL always last exactly one cycle, then enter ACCESS.
REQ-009 In ACCESS, the block SHALL drive Psel=1 and Penable=1, with Paddr, Pwrite and Pwdata held stable.
REQ-010 In ACCESS, when Pready=1 is sampled: capture Prdata (reads) and Pslverr; pulse rsp_valid for one cycle after that edge. If the FIFO is non-empty, pop and enter SETUP directly; otherwise enter IDLE.
REQ-011 A wait counter SHALL increment on each ACCESS edge with Pready=0. On reaching TIMEOUT, the block SHALL:
- abort the transfer and return to IDLE or SETUP per REQ-010;
- pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
The counter SHALL clear on entering SETUP.
REQ-012 Latency with zero wait states: command accepted at edge E0 -> SETUP after E1 -> ACCESS after E2 -> completion sampled at E3 -> rsp_valid high between E3 and E4.
REQ-013 Back-to-back commands SHALL yield exactly 2 APB cycles per transfer, with no IDLE cycle between them.
REQ-014 In IDLE, the block SHALL drive Psel=0 and Penable=0; Paddr, Pwrite and Pwdata hold their last values.
REQ-015 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next rsp_valid.
REQ-016 busy SHALL equal (state != IDLE) or (FIFO non-empty).

Reset
REQ-017 Preset=1 SHALL asynchronously force:
- all outputs to 0, except cmd_ready=1;
- FSM to IDLE, FIFO empty, wait counter 0.
REQ-018 A reset asserted mid-transfer SHALL discard the transfer and all buffered commands, with no rsp_valid emitted.
REQ-019 After reset deasserts, the first command SHALL follow the REQ-012 timing.

Structure
REQ-020 A shared package SHALL hold the FSM state type (IDLE/SETUP/ACCESS), the default widths, and the command-entry record type {write, addr, wdata}.
REQ-021 The FIFO SHALL be a separate sub-module, apb_cmd_fifo, parameterised by width and depth, with push, pop, full, empty and count; the FSM and timeout counter live in apb_master_interface.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write addr 0x0 data 0xF7 with Pready=1 -> Psel high 2 cycles, Penable high 1 cycle, then rsp_valid=1, rsp_err=0.
- Read addr 0x5 with Prdata=0x33 and Pready=1 -> rsp_rdata=0x33, rsp_err=0.
- Read addr 0x2 with Pready low 3 ACCESS cycles, then Pslverr=1 at completion -> ACCESS lasts 4 cycles, Paddr stable, rsp_err=1, rsp_timeout=0.
- Pready tied 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Push 5 commands while the bus stalls -> cmd_ready=0 after 4 are buffered; after release, 4 transfers occur back-to-back at 2 cycles each, in order.
- Preset=1 during ACCESS with 2 commands buffered -> Psel=0 immediately, busy=0, no rsp_valid.

Source files
------------

// File: rtl/apb_master_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_interface_pkg
// Purpose  : Shared types and default widths for the APB master interface:
//            FSM state type, default parameter values, command-entry record.
// Revision : 1.0 - initial release
// ============================================================================
package apb_master_interface_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 16;

  // APB master protocol phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Command-entry record at the default widths; the top declares the same
  // field order at its own parameterised widths.
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage : apb_master_interface_pkg
`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_fifo
// Purpose  : Synchronous show-ahead command FIFO (power-of-two depth) with
//            push/pop, full/empty flags and an occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  // Requests are gated by the flags so overflow/underflow cannot corrupt state
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array: data only, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : apb_cmd_fifo
`default_nettype wire

// File: rtl/apb_master_interface.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_interface
// Purpose  : Buffered APB master. Commands are queued in apb_cmd_fifo and
//            issued as SETUP/ACCESS transfers with a wait-state timeout and a
//            one-cycle response strobe per completed or aborted transfer.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_interface
  import apb_master_interface_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              Preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              Psel,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);

  localparam int CMD_W  = 1 + ADDR_W + DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  // Value of the wait counter on the last permitted stalled ACCESS edge
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_entry_t;

  cmd_entry_t        w_push_entry;
  cmd_entry_t        w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_complete;
  logic              w_abort;

  apb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  assign w_push_entry = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign w_push       = cmd_valid & ~w_fifo_full;

  apb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (PCLK),
    .rst_i   (Preset),
    .push_i  (w_push),
    .wdata_i (w_push_entry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // FSM state and wait counter registers
  always_ff @(posedge PCLK or posedge Preset) begin
    if (Preset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic: pop on entry to SETUP, complete/abort in ACCESS
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    w_pop      = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop   = 1'b1;
          state_d = ST_SETUP;
          wait_d  = '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (Pready) begin
          w_complete = 1'b1;
        end else if (wait_q == c_WAIT_LAST) begin
          w_abort = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (w_complete || w_abort) begin
          wait_d = '0;
          if (!w_fifo_empty) begin
            w_pop   = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // APB address/data registers load from the FIFO head on each pop
  always_ff @(posedge PCLK or posedge Preset) begin
    if (Preset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (w_pop) begin
      paddr_q  <= w_head.addr;
      pwrite_q <= w_head.write;
      pwdata_q <= w_head.write ? w_head.wdata : '0;
    end
  end

  // Response strobe plus sticky response fields updated only on completion
  always_ff @(posedge PCLK or posedge Preset) begin
    if (Preset) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= w_complete | w_abort;
      if (w_complete) begin
        rsp_rdata_q   <= pwrite_q ? '0 : Prdata;
        rsp_err_q     <= Pslverr;
        rsp_timeout_q <= 1'b0;
      end else if (w_abort) begin
        rsp_rdata_q   <= '0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign cmd_ready   = ~w_fifo_full;
  assign Psel        = (state_q != ST_IDLE);
  assign Penable     = (state_q == ST_ACCESS);
  assign Paddr       = paddr_q;
  assign Pwrite      = pwrite_q;
  assign Pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != ST_IDLE) || (w_fifo_count != '0);

endmodule : apb_master_interface
`default_nettype wire
